// File: rtl/uop_split_pkg.sv
// Shared uop types, opcodes and fused-imm layout used by the fusion and split stages.
package uop_split_pkg;

  localparam int NUM_UOPS_IN  = 4;
  localparam int NUM_UOPS_OUT = 3;
  localparam int BUF_SIZE     = 32;

  typedef enum logic [2:0] {
    FU_INT = 3'd0,
    FU_LSU = 3'd1,
    FU_MUL = 3'd2,
    FU_DIV = 3'd3,
    FU_FPU = 3'd4
  } fu_t;

  localparam logic [5:0] INT_ADD         = 6'd0;
  localparam logic [5:0] INT_SUB         = 6'd1;
  localparam logic [5:0] INT_XOR         = 6'd2;
  localparam logic [5:0] INT_OR          = 6'd3;
  localparam logic [5:0] INT_BEQ         = 6'd8;
  localparam logic [5:0] INT_BNE         = 6'd9;
  localparam logic [5:0] INT_BLT         = 6'd10;
  localparam logic [5:0] INT_BGE         = 6'd11;
  localparam logic [5:0] INT_BLTU        = 6'd12;
  localparam logic [5:0] INT_BGEU        = 6'd13;
  localparam logic [5:0] INT_F_ADDI_BEQ  = 6'd16;
  localparam logic [5:0] INT_F_ADDI_BNE  = 6'd17;
  localparam logic [5:0] INT_F_ADDI_BLT  = 6'd18;
  localparam logic [5:0] INT_F_ADDI_BGE  = 6'd19;
  localparam logic [5:0] INT_F_ADDI_BLTU = 6'd20;
  localparam logic [5:0] INT_F_ADDI_BGEU = 6'd21;

  // Fused imm: [31:20] addi immediate, [12:0] branch offset, bits between are unused.
  localparam int FUSED_ADDI_IMM_MSB = 31;
  localparam int FUSED_ADDI_IMM_LSB = 20;
  localparam int FUSED_BR_IMM_MSB   = 12;

  typedef struct packed {
    logic [31:0] imm;
    logic [31:0] pc;
    logic [5:0]  rs0;
    logic [5:0]  rs1;
    logic [5:0]  rd;
    logic        immB;
    logic [5:0]  opcode;
    fu_t         fu;
    logic [3:0]  branchID;
    logic        branchPred;
    logic        compressed;
    logic        valid;
  } D_UOp;

  function automatic logic [5:0] fused_to_branch(input logic [5:0] op);
    case (op)
      INT_F_ADDI_BEQ:  return INT_BEQ;
      INT_F_ADDI_BNE:  return INT_BNE;
      INT_F_ADDI_BLT:  return INT_BLT;
      INT_F_ADDI_BGE:  return INT_BGE;
      INT_F_ADDI_BLTU: return INT_BLTU;
      INT_F_ADDI_BGEU: return INT_BGEU;
      default:         return op;
    endcase
  endfunction

  function automatic logic is_fused(input D_UOp u);
    return u.valid && (u.fu == FU_INT) &&
           (u.opcode inside {INT_F_ADDI_BEQ, INT_F_ADDI_BNE, INT_F_ADDI_BLT,
                             INT_F_ADDI_BGE, INT_F_ADDI_BLTU, INT_F_ADDI_BGEU});
  endfunction

endpackage

// File: rtl/uop_split_slot.sv
// Combinational expansion of one stage slot into zero, one or two buffer entries.
module uop_split_slot
  import uop_split_pkg::*;
(
  input  D_UOp       i_uop,
  output D_UOp       o_a,
  output D_UOp       o_b,
  output logic [1:0] o_count
);

  localparam int ADDI_W = FUSED_ADDI_IMM_MSB - FUSED_ADDI_IMM_LSB + 1;
  localparam int BR_W   = FUSED_BR_IMM_MSB + 1;

  // Build the addi half and the branch half of a fused uop
  always_comb begin
    o_a     = i_uop;
    o_b     = '0;
    o_count = {1'b0, i_uop.valid};
    if (is_fused(i_uop)) begin
      o_a.opcode     = INT_ADD;
      o_a.immB       = 1'b1;
      o_a.rs0        = i_uop.rd;
      o_a.imm        = {{(32-ADDI_W){i_uop.imm[FUSED_ADDI_IMM_MSB]}},
                        i_uop.imm[FUSED_ADDI_IMM_MSB:FUSED_ADDI_IMM_LSB]};
      o_a.branchPred = 1'b0;
      o_b            = i_uop;
      o_b.opcode     = fused_to_branch(i_uop.opcode);
      o_b.rd         = 6'd0;
      o_b.immB       = 1'b0;
      o_b.imm        = {{(32-BR_W){i_uop.imm[FUSED_BR_IMM_MSB]}},
                        i_uop.imm[FUSED_BR_IMM_MSB:0]};
      o_count        = 2'd2;
    end else begin
      o_b = '0;
    end
  end

endmodule

// File: rtl/uop_split.sv
// Splits fused addi+branch uops back into two uops and decouples the stream
// through a ring buffer; program order is preserved end to end.
module uop_split
  import uop_split_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic frontEn,
  input  logic mispredict,
  output logic OUT_full,
  input  D_UOp IN_uop  [NUM_UOPS_IN],
  output D_UOp OUT_uop [NUM_UOPS_OUT]
);

  localparam int IDX_W   = $clog2(BUF_SIZE);
  localparam int MAX_ENT = 2 * NUM_UOPS_IN;
  localparam int ENT_IW  = $clog2(MAX_ENT);
  localparam int CNT_W   = $clog2(MAX_ENT + 1);
  localparam int POP_W   = $clog2(NUM_UOPS_OUT + 1);

  D_UOp             r_stage [NUM_UOPS_IN];
  D_UOp             r_buf   [BUF_SIZE];
  D_UOp             r_out   [NUM_UOPS_OUT];
  logic [IDX_W-1:0] r_idx_in;
  logic [IDX_W-1:0] r_idx_out;
  logic [IDX_W:0]   r_free;
  logic             r_full;

  D_UOp             w_a       [NUM_UOPS_IN];
  D_UOp             w_b       [NUM_UOPS_IN];
  logic [1:0]       w_cnt     [NUM_UOPS_IN];
  D_UOp             w_ent     [MAX_ENT];
  logic [CNT_W-1:0] w_n_ent;
  logic [CNT_W-1:0] w_n_ins;
  logic [POP_W-1:0] w_n_pop;
  logic [IDX_W:0]   w_occ;
  logic [IDX_W:0]   w_free_next;

  for (genvar g = 0; g < NUM_UOPS_IN; g++) begin : g_slot
    uop_split_slot u_slot (
      .i_uop   (r_stage[g]),
      .o_a     (w_a[g]),
      .o_b     (w_b[g]),
      .o_count (w_cnt[g])
    );
  end

  // Compact slot expansions into a dense, in-order entry list
  always_comb begin
    w_n_ent = '0;
    for (int k = 0; k < MAX_ENT; k++) begin
      w_ent[k] = '0;
    end
    for (int i = 0; i < NUM_UOPS_IN; i++) begin
      if (w_cnt[i] != 2'd0) begin
        w_ent[w_n_ent[ENT_IW-1:0]] = w_a[i];
        w_n_ent = w_n_ent + CNT_W'(1);
      end else begin
        w_n_ent = w_n_ent;
      end
      if (w_cnt[i] == 2'd2) begin
        w_ent[w_n_ent[ENT_IW-1:0]] = w_b[i];
        w_n_ent = w_n_ent + CNT_W'(1);
      end else begin
        w_n_ent = w_n_ent;
      end
    end
  end

  // Occupancy comes from free, so a completely full buffer (idx_in==idx_out) still drains
  always_comb begin
    w_occ   = (IDX_W+1)'(BUF_SIZE) - r_free;
    w_n_ins = r_full ? '0 : w_n_ent;
    if (!frontEn) begin
      w_n_pop = '0;
    end else if (w_occ >= (IDX_W+1)'(NUM_UOPS_OUT)) begin
      w_n_pop = POP_W'(NUM_UOPS_OUT);
    end else begin
      w_n_pop = w_occ[POP_W-1:0];
    end
    w_free_next = r_free + (IDX_W+1)'(w_n_pop) - (IDX_W+1)'(w_n_ins);
  end

  // Stage register, output pops, ring indices and stall flag
  always_ff @(posedge clk) begin
    if (rst || mispredict) begin
      for (int i = 0; i < NUM_UOPS_IN; i++) begin
        r_stage[i] <= '0;
      end
      for (int i = 0; i < NUM_UOPS_OUT; i++) begin
        r_out[i] <= '0;
      end
      r_idx_in  <= '0;
      r_idx_out <= '0;
      r_free    <= (IDX_W+1)'(BUF_SIZE);
      r_full    <= 1'b0;
    end else begin
      if (!r_full) begin
        r_stage <= IN_uop;
      end
      if (frontEn) begin
        for (int i = 0; i < NUM_UOPS_OUT; i++) begin
          if (POP_W'(i) < w_n_pop) begin
            r_out[i] <= r_buf[r_idx_out + IDX_W'(i)];
          end else begin
            r_out[i] <= '0;
          end
        end
      end
      r_idx_out <= r_idx_out + IDX_W'(w_n_pop);
      r_idx_in  <= r_idx_in + IDX_W'(w_n_ins);
      r_free    <= w_free_next;
      r_full    <= (w_free_next < (IDX_W+1)'(MAX_ENT));
    end
  end

  // Buffer payload is never cleared; indices alone define what is live
  always_ff @(posedge clk) begin
    for (int k = 0; k < MAX_ENT; k++) begin
      if (CNT_W'(k) < w_n_ins) begin
        r_buf[r_idx_in + IDX_W'(k)] <= w_ent[k];
      end
    end
  end

  assign OUT_uop  = r_out;
  assign OUT_full = r_full;

endmodule

// File: tb/tb_uop_split.sv
// Randomized bench for uop_split: queue-level reference model compared every cycle,
// plus literal checks on passthrough, split fields, stall, flush and holes.
module tb_uop_split;
  import uop_split_pkg::*;

  logic clk = 1'b0;
  logic rst, frontEn, mispredict;
  logic OUT_full;
  D_UOp IN_uop  [NUM_UOPS_IN];
  D_UOp OUT_uop [NUM_UOPS_OUT];

  int n_checks = 0;
  int n_errors = 0;

  D_UOp m_stage[$];
  D_UOp m_buf[$];
  D_UOp m_out [NUM_UOPS_OUT];
  logic m_full;

  always #5 clk = ~clk;

  uop_split dut (
    .clk        (clk),
    .rst        (rst),
    .frontEn    (frontEn),
    .mispredict (mispredict),
    .OUT_full   (OUT_full),
    .IN_uop     (IN_uop),
    .OUT_uop    (OUT_uop)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] branch_of(input logic [5:0] op);
    case (op)
      INT_F_ADDI_BEQ:  return INT_BEQ;
      INT_F_ADDI_BNE:  return INT_BNE;
      INT_F_ADDI_BLT:  return INT_BLT;
      INT_F_ADDI_BGE:  return INT_BGE;
      INT_F_ADDI_BLTU: return INT_BLTU;
      INT_F_ADDI_BGEU: return INT_BGEU;
      default:         return 6'h3F;
    endcase
  endfunction

  // Expand the current inputs into the model stage (what a stage capture would hold)
  function automatic void model_capture();
    m_stage.delete();
    for (int i = 0; i < NUM_UOPS_IN; i++) begin
      D_UOp u, a, b;
      int va, vb;
      u = IN_uop[i];
      if (u.valid) begin
        if (u.fu == FU_INT && branch_of(u.opcode) != 6'h3F) begin
          va = int'(u.imm[31:20]);
          if (va >= 2048) va = va - 4096;
          vb = int'(u.imm[12:0]);
          if (vb >= 4096) vb = vb - 8192;
          a = u; a.opcode = INT_ADD; a.immB = 1'b1; a.rs0 = u.rd;
          a.imm = 32'(va); a.branchPred = 1'b0;
          b = u; b.opcode = branch_of(u.opcode); b.rd = 6'd0; b.immB = 1'b0;
          b.imm = 32'(vb);
          m_stage.push_back(a);
          m_stage.push_back(b);
        end else begin
          m_stage.push_back(u);
        end
      end
    end
  endfunction

  task automatic model_step();
    if (rst || mispredict) begin
      m_stage.delete();
      m_buf.delete();
      for (int i = 0; i < NUM_UOPS_OUT; i++) m_out[i] = '0;
      m_full = 1'b0;
    end else begin
      if (frontEn) begin
        for (int i = 0; i < NUM_UOPS_OUT; i++) begin
          if (m_buf.size() > 0) m_out[i] = m_buf.pop_front();
          else m_out[i] = '0;
        end
      end
      if (!m_full) begin
        foreach (m_stage[k]) m_buf.push_back(m_stage[k]);
        model_capture();
      end
      m_full = (BUF_SIZE - m_buf.size()) < 2 * NUM_UOPS_IN;
    end
  endtask

  task automatic compare();
    check("full", 128'(OUT_full), 128'(m_full));
    for (int i = 0; i < NUM_UOPS_OUT; i++) begin
      check($sformatf("out%0d_valid", i), 128'(OUT_uop[i].valid), 128'(m_out[i].valid));
      if (m_out[i].valid) check($sformatf("out%0d_uop", i), 128'(OUT_uop[i]), 128'(m_out[i]));
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_UOPS_OUT; i++) m_out[i] = '0;
    m_full = 1'b0;
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
    end
  end

  function automatic D_UOp mk(input logic [5:0] op, input logic [31:0] pc, input logic [5:0] rd,
                              input logic [5:0] rs0, input logic [5:0] rs1, input logic [31:0] imm);
    D_UOp u;
    u = '0;
    u.opcode = op; u.pc = pc; u.rd = rd; u.rs0 = rs0; u.rs1 = rs1; u.imm = imm;
    u.fu = FU_INT; u.branchID = 4'd3; u.branchPred = 1'b1; u.valid = 1'b1;
    return u;
  endfunction

  function automatic D_UOp rand_uop(input logic [31:0] pc);
    D_UOp u;
    u = '0;
    u.imm = $urandom; u.pc = pc;
    u.rs0 = 6'($urandom_range(0, 63)); u.rs1 = 6'($urandom_range(0, 63));
    u.rd = 6'($urandom_range(0, 63));
    u.branchID = 4'($urandom_range(0, 15)); u.branchPred = 1'($urandom_range(0, 1));
    u.compressed = 1'($urandom_range(0, 1));
    u.fu = ($urandom_range(0, 4) == 0) ? FU_LSU : FU_INT;
    if ($urandom_range(0, 2) == 0) begin
      u.opcode = INT_F_ADDI_BEQ + 6'($urandom_range(0, 5));
      u.rs0 = u.rd;
    end else begin
      u.opcode = 6'($urandom_range(0, 13));
    end
    u.valid = 1'b1;
    return u;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_in();
    for (int i = 0; i < NUM_UOPS_IN; i++) IN_uop[i] = '0;
  endtask

  initial begin
    int sent;
    logic [31:0] pc;
    rst = 1'b1; frontEn = 1'b0; mispredict = 1'b0;
    clear_in();
    step(3);
    check("rst_full", 128'(OUT_full), 128'(0));
    check("rst_valid0", 128'(OUT_uop[0].valid), 128'(0));
    rst = 1'b0;
    step(1);

    // Passthrough: 4 plain uops, 3 out at t+3 and 1 at t+4
    frontEn = 1'b1;
    for (int i = 0; i < 4; i++) IN_uop[i] = mk(INT_ADD, 32'h100 + 32'(4 * i), 6'd1, 6'd2, 6'd3, 32'd7);
    step(1); clear_in(); step(2);
    check("t1_pc0", 128'(OUT_uop[0].pc), 128'(32'h100));
    check("t1_pc1", 128'(OUT_uop[1].pc), 128'(32'h104));
    check("t1_pc2", 128'(OUT_uop[2].pc), 128'(32'h108));
    check("t1_v2", 128'(OUT_uop[2].valid), 128'(1));
    step(1);
    check("t1_pc3", 128'(OUT_uop[0].pc), 128'(32'h10C));
    check("t1_v1_late", 128'(OUT_uop[1].valid), 128'(0));

    // Split fields of a fused BNE
    IN_uop[0] = mk(INT_F_ADDI_BNE, 32'h400, 6'd5, 6'd5, 6'd6, {12'hFFF, 7'b0, 13'h1FF0});
    step(1); clear_in(); step(2);
    check("t2_a_op", 128'(OUT_uop[0].opcode), 128'(INT_ADD));
    check("t2_a_rs0", 128'(OUT_uop[0].rs0), 128'(5));
    check("t2_a_rd", 128'(OUT_uop[0].rd), 128'(5));
    check("t2_a_imm", 128'(OUT_uop[0].imm), 128'(32'hFFFFFFFF));
    check("t2_a_immB", 128'(OUT_uop[0].immB), 128'(1));
    check("t2_a_pred", 128'(OUT_uop[0].branchPred), 128'(0));
    check("t2_b_op", 128'(OUT_uop[1].opcode), 128'(INT_BNE));
    check("t2_b_rs", 128'({OUT_uop[1].rs0, OUT_uop[1].rs1}), 128'({6'd5, 6'd6}));
    check("t2_b_imm", 128'(OUT_uop[1].imm), 128'(32'hFFFFFFF0));
    check("t2_b_rd", 128'(OUT_uop[1].rd), 128'(0));
    check("t2_b_pc", 128'(OUT_uop[1].pc), 128'(32'h400));
    check("t2_b_pred", 128'(OUT_uop[1].branchPred), 128'(1));
    check("t2_v2", 128'(OUT_uop[2].valid), 128'(0));

    // Holes: valids 1010 with a fused slot3
    IN_uop[1] = mk(INT_SUB, 32'h200, 6'd9, 6'd8, 6'd7, 32'd0);
    IN_uop[3] = mk(INT_F_ADDI_BEQ, 32'h300, 6'd4, 6'd4, 6'd2, 32'h0010_0008);
    step(1); clear_in(); step(2);
    check("t6_e0", 128'({OUT_uop[0].opcode, OUT_uop[0].pc}), 128'({INT_SUB, 32'h200}));
    check("t6_e1", 128'({OUT_uop[1].opcode, OUT_uop[1].immB, OUT_uop[1].pc}), 128'({INT_ADD, 1'b1, 32'h300}));
    check("t6_e2", 128'({OUT_uop[2].opcode, OUT_uop[2].imm}), 128'({INT_BEQ, 32'd8}));
    step(2);

    // Full: consumer stalled, 8 entries per cycle until the buffer saturates
    frontEn = 1'b0;
    pc = 32'h1000;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 4; i++) begin
        IN_uop[i] = mk(INT_F_ADDI_BLT, pc, 6'd3, 6'd3, 6'd1, $urandom);
        pc = pc + 32'd4;
      end
      step(1);
    end
    check("t3_full", 128'(OUT_full), 128'(1));
    clear_in();
    frontEn = 1'b1;
    step(20);
    check("t3_drained", 128'(OUT_full), 128'(0));

    // Flush with 20 entries buffered
    frontEn = 1'b0;
    for (int i = 0; i < 4; i++) IN_uop[i] = mk(INT_F_ADDI_BGE, 32'h500 + 32'(4 * i), 6'd2, 6'd2, 6'd1, 32'h0);
    step(1);
    for (int i = 0; i < 4; i++) IN_uop[i] = mk(INT_F_ADDI_BGEU, 32'h600 + 32'(4 * i), 6'd2, 6'd2, 6'd1, 32'h0);
    step(1);
    for (int i = 0; i < 4; i++) IN_uop[i] = mk(INT_XOR, 32'h700 + 32'(4 * i), 6'd2, 6'd2, 6'd1, 32'h0);
    step(1); clear_in(); step(2);
    mispredict = 1'b1;
    step(1);
    mispredict = 1'b0;
    check("t5_full", 128'(OUT_full), 128'(0));
    check("t5_v0", 128'(OUT_uop[0].valid), 128'(0));
    frontEn = 1'b1;
    IN_uop[0] = mk(INT_OR, 32'h900, 6'd1, 6'd1, 6'd1, 32'h0);
    step(1); clear_in(); step(2);
    check("t5_first", 128'({OUT_uop[0].valid, OUT_uop[0].pc}), 128'({1'b1, 32'h900}));
    check("t5_nostale", 128'(OUT_uop[1].valid), 128'(0));

    // Random mixed stream with random consumer enable
    sent = 0;
    pc = 32'h8000;
    while (sent < 100) begin
      frontEn = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) != 0 && sent < 100) begin
          IN_uop[i] = rand_uop(pc);
          pc = pc + 32'd4;
          sent++;
        end else begin
          IN_uop[i] = '0;
        end
      end
      step(1);
    end
    clear_in();
    frontEn = 1'b1;
    step(30);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
